tdc_pulse_gen: RTL
==================

# tdc_pulse_gen

Programmable start/stop edge-pair generator feeding the ring-oscillator TDC tile. It produces a start pulse and a stop pulse separated by a configured whole-cycle delay, in bursts of one or more pairs. The TDC's measured codes can then be checked against known intervals on silicon. It sits inside the tile top, between the configuration registers (ui_in/uio_in) and the TDC start/stop inputs, driven from the tile clock.

## Interface
- CNT_W, 8: width of cfg_delay, cfg_width, cfg_gap.
- BURST_W, 4: width of cfg_count and pair_idx.

- clk  input  1  tile clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  launch request; accepted only while ready=1.
- abort  input  1  synchronous cancel of a running burst.
- cfg_delay  input  CNT_W  D: stop rises D+1 cycles after start rises.
- cfg_width  input  CNT_W  W: each pulse is high W+1 cycles.
- cfg_count  input  BURST_W  N: burst length is N+1 pairs.
- cfg_gap  input  CNT_W  G: low cycles between pairs are G+1. Port exists only with TDC_PULSE_GEN_GAP_EN.
- ready  output  1  idle, can accept go.
- busy  output  1  burst in progress (equals ~ready).
- start_out  output  1  registered start pulse to the TDC.
- stop_out  output  1  registered stop pulse to the TDC.
- done  output  1  one-cycle pulse when a burst completes normally.
- pair_idx  output  BURST_W  index (0..N) of the current pair.

## Operation
- FSM states:
  - IDLE: ready=1.
  - PAIR: pair counter cnt runs 0..D+W+1.
  - GAP: gap counter runs 0..Gl-1.
- IDLE, go=1, abort=0: latch D, W, N (and G). Go to PAIR with cnt=0, pair_idx=0.
- Config inputs are sampled only at acceptance. Later changes have no effect until the next burst.
- PAIR:
  - start_out = (cnt <= W).
  - stop_out = (cnt >= D+1) && (cnt <= D+1+W).
  - Start and stop may overlap when W >= D+1. This is legal.
  - cnt width is CNT_W+1 bits; the maximum D+W+1 never wraps.
- Last cnt value of a pair with pair_idx < N: go to GAP. With pair_idx == N: go to IDLE and assert done for one cycle.
- GAP: both outputs low. After Gl cycles, go to PAIR with cnt=0 and pair_idx+1.
  - Gl = 1 without the macro, G+1 with it.
- abort=1 in PAIR or GAP: next cycle is IDLE, outputs low, no done, pair_idx=0.
- abort=1 in IDLE, or together with go: go is ignored (abort wins).
- go while busy: ignored, no queueing.
- Reset values: ready=1, busy=0, start_out=0, stop_out=0, done=0, pair_idx=0. Reset mid-burst behaves like abort and overrides it.

## Timing
- go sampled high at edge k (ready=1):
  - start_out high in cycles k+1 .. k+1+W.
  - stop_out high in cycles k+D+2 .. k+D+2+W.
- Pair length is D+W+2 cycles. The next pair's start rises D+W+2+Gl cycles after the previous start.
- No gap after the last pair. done=1 and ready=1 in the cycle after the final pair's last cycle.
  - A go sampled in that cycle is accepted (back-to-back bursts).
- Start-to-stop rising-edge separation is exactly D+1 clk periods, with zero jitter added by this block.
- All outputs come directly from flops; no combinational path from inputs to outputs.

## Configuration
- TDC_PULSE_GEN_GAP_EN defined: cfg_gap port present; inter-pair gap is cfg_gap+1 cycles, latched at go.
- Undefined: no cfg_gap port, no gap register; gap is fixed at 1 cycle.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then D=3, W=0, N=0, go at cycle 0:
  - start_out high cycle 1 only; stop_out high cycle 5 only.
  - done high cycle 6; ready high again cycle 6.
- D=0, W=1, N=2, no macro:
  - start highs at cycles 1–2, 5–6, 9–10; stop highs at 2–3, 6–7, 10–11.
  - pair_idx 0/1/2; done at cycle 12.
- Same burst with abort at cycle 6: outputs low from cycle 7, ready=1 at 7, done never asserted. go at 7 restarts from pair 0.
- go pulsed at cycles 3 and 6 during a D=5, W=0, N=0 burst: ignored; exactly one pair generated.
  - Then go coincident with done: a second burst starts the next cycle.
- rst asserted at cycle 4 of a D=7, W=2 burst: all outputs at reset values from cycle 5.
  - go together with abort in IDLE: nothing launched.
- With TDC_PULSE_GEN_GAP_EN, D=1, W=0, N=1, G=4:
  - starts at cycles 1 and 9; stops at 3 and 11; done at 12.

Source files
------------

// File: rtl/tdc_pulse_gen.sv
// Start/stop edge-pair generator for TDC calibration: bursts of N+1 pairs, stop trails start by D+1 cycles.
// Optional TDC_PULSE_GEN_GAP_EN adds cfg_gap (inter-pair gap of G+1 cycles); otherwise the gap is 1 cycle.
module tdc_pulse_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cfg_delay,
  input  logic [CNT_W-1:0]   cfg_width,
  input  logic [BURST_W-1:0] cfg_count,
`ifdef TDC_PULSE_GEN_GAP_EN
  input  logic [CNT_W-1:0]   cfg_gap,
`endif
  output logic               ready,
  output logic               busy,
  output logic               start_out,
  output logic               stop_out,
  output logic               done,
  output logic [BURST_W-1:0] pair_idx
);

  typedef enum logic [1:0] {IDLE, PAIR, GAP} state_t;

  state_t             state;
  logic [CNT_W:0]     cnt;
  logic [CNT_W-1:0]   d_q;
  logic [CNT_W-1:0]   w_q;
  logic [BURST_W-1:0] n_q;

  logic [CNT_W:0] d_ext;
  logic [CNT_W:0] w_ext;
  logic [CNT_W:0] stop_lo;
  logic [CNT_W:0] last_cnt;
  logic [CNT_W:0] cnt_nx;
  logic           gap_last;

  assign d_ext    = {1'b0, d_q};
  assign w_ext    = {1'b0, w_q};
  assign stop_lo  = d_ext + (CNT_W+1)'(1);
  // The stop window ends exactly on the last count of the pair, so last_cnt doubles as its upper bound.
  assign last_cnt = stop_lo + w_ext;
  assign cnt_nx   = cnt + (CNT_W+1)'(1);

`ifdef TDC_PULSE_GEN_GAP_EN
  logic [CNT_W-1:0] g_q;
  logic [CNT_W-1:0] gcnt;
  assign gap_last = (gcnt == g_q);
`else
  assign gap_last = 1'b1;
`endif

  // Outputs are registered from the next count value so each pulse lines up with its cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      d_q       <= '0;
      w_q       <= '0;
      n_q       <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      start_out <= 1'b0;
      stop_out  <= 1'b0;
      done      <= 1'b0;
      pair_idx  <= '0;
`ifdef TDC_PULSE_GEN_GAP_EN
      g_q       <= '0;
      gcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go && !abort) begin
            d_q       <= cfg_delay;
            w_q       <= cfg_width;
            n_q       <= cfg_count;
`ifdef TDC_PULSE_GEN_GAP_EN
            g_q       <= cfg_gap;
`endif
            state     <= PAIR;
            cnt       <= '0;
            pair_idx  <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            start_out <= 1'b1;
            stop_out  <= 1'b0;
          end
        end
        PAIR: begin
          if (abort) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            start_out <= 1'b0;
            stop_out  <= 1'b0;
            pair_idx  <= '0;
          end else if (cnt == last_cnt) begin
            start_out <= 1'b0;
            stop_out  <= 1'b0;
            if (pair_idx == n_q) begin
              state    <= IDLE;
              ready    <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              pair_idx <= '0;
            end else begin
              state <= GAP;
`ifdef TDC_PULSE_GEN_GAP_EN
              gcnt  <= '0;
`endif
            end
          end else begin
            cnt       <= cnt_nx;
            start_out <= (cnt_nx <= w_ext);
            stop_out  <= (cnt_nx >= stop_lo);
          end
        end
        GAP: begin
          if (abort) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            pair_idx <= '0;
          end else if (gap_last) begin
            state     <= PAIR;
            cnt       <= '0;
            pair_idx  <= pair_idx + BURST_W'(1);
            start_out <= 1'b1;
          end else begin
`ifdef TDC_PULSE_GEN_GAP_EN
            gcnt <= gcnt + CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
